// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes and bounce direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_PULSE  = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_WALK   = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_e;

    // "Right" moves the lit LED toward the LSB.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/led_tick_cnt.sv
// Tick counter with a greater-or-equal period compare; flags the wrapping tick
// combinationally (step_o) and as a registered one-cycle pulse (wrap_o).
module led_tick_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             step_o,
    output logic             wrap_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_s;
    logic             hit_s;
    logic             wrap_q;

    // Terminal count and next count; a period of 0 behaves like 1.
    always_comb begin
        last_s = (period_i == '0) ? '0 : (period_i - CNT_W'(1));
        hit_s  = en_i & tick_i & (cnt_q >= last_s);
        if (!en_i) begin
            cnt_d = '0;
        end else if (hit_s) begin
            cnt_d = '0;
        end else if (tick_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and wrap pulse registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= hit_s;
        end
    end

    assign step_o = hit_s;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: PULSE / TOGGLE / WALK / BOUNCE patterns stepped once per
// period of time-base ticks, with registered, polarity-selectable LED drive.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int N_LED      = 8,
    parameter int CNT_W      = 10,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pls_1k,
    input  logic             i_go,
    input  logic [1:0]       i_mode,
    input  logic [CNT_W-1:0] i_period,
    output logic [N_LED-1:0] o_led_on,
    output logic             o_wrap
);

    localparam logic [N_LED-1:0] MSB_ONE = N_LED'(1) << (N_LED - 1);

    logic             start_q;
    logic             active_q;
    logic             first_s;
    logic             step_s;
    logic             wrap_s;
    mode_e            mode_q;
    mode_e            mode_d;
    mode_e            mode_in_s;
    logic             dir_q;
    logic             dir_d;
    logic [N_LED-1:0] pattern_q;
    logic [N_LED-1:0] pattern_d;
    logic [N_LED-1:0] led_q;
    logic [N_LED-1:0] led_d;

    led_tick_cnt #(
        .CNT_W (CNT_W)
    ) u_tick_cnt (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .en_i     (start_q),
        .tick_i   (i_pls_1k),
        .period_i (i_period),
        .step_o   (step_s),
        .wrap_o   (wrap_s)
    );

    // Run-state register: start_q is RUN, active_q marks that RUN was already entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            start_q  <= i_go;
            active_q <= start_q;
        end
    end

    // Next pattern, direction and latched mode.
    always_comb begin
        first_s   = start_q & ~active_q;
        mode_in_s = mode_e'(i_mode);
        pattern_d = pattern_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        if (!start_q) begin
            pattern_d = '0;
            dir_d     = DIR_RIGHT;
        end else if (first_s || (step_s && (mode_in_s != mode_q))) begin
            mode_d    = mode_in_s;
            dir_d     = DIR_RIGHT;
            pattern_d = ((mode_in_s == MODE_WALK) || (mode_in_s == MODE_BOUNCE)) ? MSB_ONE : '0;
        end else if (step_s) begin
            case (mode_q)
                MODE_PULSE:  pattern_d = MSB_ONE;
                MODE_TOGGLE: pattern_d = ~pattern_q;
                MODE_WALK:   pattern_d = (pattern_q >> 1) | (pattern_q << (N_LED - 1));
                MODE_BOUNCE: begin
                    if (N_LED == 1) begin
                        pattern_d = pattern_q;
                    end else if (dir_q == DIR_RIGHT) begin
                        // At an end the LED turns back immediately so each end is lit one step.
                        if (pattern_q[0]) begin
                            pattern_d = pattern_q << 1;
                            dir_d     = DIR_LEFT;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end else begin
                        if (pattern_q[N_LED-1]) begin
                            pattern_d = pattern_q >> 1;
                            dir_d     = DIR_RIGHT;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end
                end
                default:     pattern_d = '0;
            endcase
        end else if (mode_q == MODE_PULSE) begin
            pattern_d = '0;
        end else begin
            pattern_d = pattern_q;
        end
    end

    // Output drive polarity.
    always_comb begin
        if (ACTIVE_LOW != 0) begin
            led_d = ~pattern_d;
        end else begin
            led_d = pattern_d;
        end
    end

    // Pattern state and registered LED drive.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pattern_q <= '0;
            dir_q     <= DIR_RIGHT;
            mode_q    <= MODE_PULSE;
            led_q     <= (ACTIVE_LOW != 0) ? '1 : '0;
        end else begin
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            led_q     <= led_d;
        end
    end

    assign o_led_on = led_q;
    assign o_wrap   = wrap_s;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: four parameterisations share one stimulus,
// each scenario checks the instance whose parameters it targets.
module tb_led_pattern_gen;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pls_1k = 1'b0;
    logic        i_go = 1'b0;
    logic [1:0]  i_mode = 2'b00;
    logic [9:0]  i_period = 10'd1;

    logic [7:0]  led_a, led_b;
    logic [3:0]  led_c;
    logic [0:0]  led_d;
    logic        wrap_a, wrap_b, wrap_c, wrap_d;

    int n_vec = 0;
    int n_bad = 0;

    always #5 i_clk = ~i_clk;

    led_pattern_gen #(.N_LED(8), .CNT_W(10), .ACTIVE_LOW(1)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_pls_1k(i_pls_1k), .i_go(i_go),
        .i_mode(i_mode), .i_period(i_period), .o_led_on(led_a), .o_wrap(wrap_a));
    led_pattern_gen #(.N_LED(8), .CNT_W(10), .ACTIVE_LOW(0)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_pls_1k(i_pls_1k), .i_go(i_go),
        .i_mode(i_mode), .i_period(i_period), .o_led_on(led_b), .o_wrap(wrap_b));
    led_pattern_gen #(.N_LED(4), .CNT_W(10), .ACTIVE_LOW(0)) dut_c (
        .i_clk(i_clk), .i_rst(i_rst), .i_pls_1k(i_pls_1k), .i_go(i_go),
        .i_mode(i_mode), .i_period(i_period), .o_led_on(led_c), .o_wrap(wrap_c));
    led_pattern_gen #(.N_LED(1), .CNT_W(10), .ACTIVE_LOW(0)) dut_d (
        .i_clk(i_clk), .i_rst(i_rst), .i_pls_1k(i_pls_1k), .i_go(i_go),
        .i_mode(i_mode), .i_period(i_period), .o_led_on(led_d), .o_wrap(wrap_d));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock with an optional tick; outputs are settled on return.
    task automatic step(input logic pls);
        i_pls_1k = pls;
        @(posedge i_clk);
        #1;
        i_pls_1k = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_go  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            check_val("rst_led", {24'd0, led_a}, 32'h0000_00FF);
            check_val("rst_wrap", {31'd0, wrap_a}, 32'd0);
        end
        check_val("rst_led_b", {24'd0, led_b}, 32'd0);
        i_rst = 1'b0;
        i_go  = 1'b0;
        step(1'b0);
        check_val("post_rst_led", {24'd0, led_a}, 32'h0000_00FF);
    endtask

    logic [7:0] walk_exp [9]   = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    logic [3:0] bounce_exp [8] = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4};

    initial begin
        // PULSE, period 3, one tick every 4 clocks
        do_reset();
        i_mode = 2'b00; i_period = 10'd3; i_go = 1'b1;
        step(1'b0);
        for (int k = 0; k < 9; k++) begin
            step(1'b1);
            check_val("pulse_wrap", {31'd0, wrap_a}, (k % 3 == 2) ? 32'd1 : 32'd0);
            check_val("pulse_led", {24'd0, led_a}, (k % 3 == 2) ? 32'h7F : 32'hFF);
            step(1'b0);
            check_val("pulse_wrap_off", {31'd0, wrap_a}, 32'd0);
            check_val("pulse_led_off", {24'd0, led_a}, 32'hFF);
            step(1'b0);
            step(1'b0);
        end

        // WALK, period 1, active-high drive
        do_reset();
        i_mode = 2'b10; i_period = 10'd1; i_go = 1'b1;
        step(1'b0);
        for (int k = 0; k < 9; k++) begin
            step(1'b1);
            check_val("walk_led", {24'd0, led_b}, {24'd0, walk_exp[k]});
            check_val("walk_wrap", {31'd0, wrap_b}, 32'd1);
            check_val("walk_n1", {31'd0, led_d}, 32'd1);
        end

        // BOUNCE on 4 LEDs, then switch to TOGGLE
        do_reset();
        i_mode = 2'b11; i_period = 10'd1; i_go = 1'b1;
        step(1'b0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1);
            check_val("bounce_led", {28'd0, led_c}, {28'd0, bounce_exp[k]});
            check_val("bounce_n1", {31'd0, led_d}, 32'd1);
        end
        i_mode = 2'b01;
        step(1'b0);
        check_val("bounce_hold", {28'd0, led_c}, 32'h4);
        step(1'b1);
        check_val("switch_init", {28'd0, led_c}, 32'h0);
        step(1'b1);
        check_val("switch_toggle", {28'd0, led_c}, 32'hF);

        // Drop go at cnt=5, re-raise after 3 cycles, expect a fresh count
        do_reset();
        i_mode = 2'b01; i_period = 10'd10; i_go = 1'b1;
        step(1'b0);
        for (int k = 0; k < 5; k++) step(1'b1);
        check_val("pre_drop_wrap", {31'd0, wrap_a}, 32'd0);
        i_go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
        end
        check_val("idle_led", {24'd0, led_a}, 32'hFF);
        check_val("idle_wrap", {31'd0, wrap_a}, 32'd0);
        i_go = 1'b1;
        step(1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            check_val("restart_wrap", {31'd0, wrap_a}, (k == 9) ? 32'd1 : 32'd0);
            check_val("restart_led", {24'd0, led_a}, (k == 9) ? 32'h00 : 32'hFF);
        end

        // Period 0 wraps every tick; shrinking the period forces a wrap
        do_reset();
        i_mode = 2'b00; i_period = 10'd0; i_go = 1'b1;
        step(1'b0);
        step(1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            check_val("p0_wrap", {31'd0, wrap_a}, 32'd1);
            check_val("p0_led", {24'd0, led_a}, 32'h7F);
        end
        i_period = 10'd10;
        for (int k = 0; k < 7; k++) begin
            step(1'b1);
            check_val("p10_wrap", {31'd0, wrap_a}, 32'd0);
        end
        i_period = 10'd2;
        step(1'b1);
        check_val("shrink_wrap", {31'd0, wrap_a}, 32'd1);
        step(1'b0);
        check_val("shrink_wrap_off", {31'd0, wrap_a}, 32'd0);
        step(1'b1);
        check_val("p2_first", {31'd0, wrap_a}, 32'd0);

        // go falls together with the wrapping tick: the tick still counts
        i_go = 1'b0;
        step(1'b1);
        check_val("go_fall_wrap", {31'd0, wrap_a}, 32'd1);
        check_val("go_fall_led", {24'd0, led_a}, 32'h7F);
        step(1'b1);
        check_val("go_fall_idle_wrap", {31'd0, wrap_a}, 32'd0);
        check_val("go_fall_idle_led", {24'd0, led_a}, 32'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter N_LED, default 8, number of LED outputs (1..32).
REQ-002 SHALL have parameter CNT_W, default 10, width of the tick counter and of i_period.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; when 1, a lit LED drives 0.
REQ-004 SHALL have port i_clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_pls_1k  in  1  one-cycle time-base tick.
REQ-007 SHALL have port i_go  in  1  level run enable.
REQ-008 SHALL have port i_mode  in  2  pattern select: 00 PULSE, 01 TOGGLE, 10 WALK, 11 BOUNCE.
REQ-009 SHALL have port i_period  in  CNT_W  number of ticks per pattern step; 0 is treated as 1.
REQ-010 SHALL have port o_led_on  out  N_LED  registered LED drive, polarity per ACTIVE_LOW.
REQ-011 SHALL have port o_wrap  out  1  one-cycle pulse on each period wrap.

Function
REQ-012 SHALL register i_go into r_start; state is RUN when r_start=1 and IDLE otherwise, so entry and exit each take 1 cycle of latency.
REQ-013 In IDLE, SHALL hold the counter at 0, the pattern at 0 with all LEDs dark, o_wrap=0, and the direction flag at "right".
REQ-014 In RUN, SHALL do nothing on a cycle without a tick; on a tick SHALL wrap the counter to 0 if cnt >= max(i_period,1)-1, and otherwise increment it.
REQ-015 Because of the >= compare, lowering i_period while running SHALL cause a wrap on the next tick; the counter SHALL never overflow.
REQ-016 SHALL assert o_wrap in the cycle after the wrapping tick, and SHALL update the pattern in that same cycle.
REQ-017 SHALL load the pattern to the initial value of i_mode on the first RUN cycle. Initial values: PULSE 0; TOGGLE 0; WALK MSB set; BOUNCE MSB set with direction right.
REQ-018 SHALL sample i_mode only on the first RUN cycle and at each wrap. If the value at a wrap differs from the latched mode, SHALL load the initial value of the new mode instead of advancing.
REQ-019 PULSE: SHALL light only the MSB, for exactly the one cycle in which o_wrap is high, and keep it dark at all other times.
REQ-020 TOGGLE: SHALL invert all N_LED bits at each wrap.
REQ-021 WALK: SHALL shift the pattern one position toward the LSB at each wrap; the lit LED at the LSB SHALL return to the MSB.
REQ-022 BOUNCE: SHALL shift the lit LED one position at each wrap in the current direction, and SHALL reverse direction when it reaches the LSB or MSB. The end LEDs SHALL each be lit for exactly one step per sweep.
REQ-023 With N_LED=1, WALK and BOUNCE SHALL keep the single LED lit.
REQ-024 If i_go falls in the same cycle as a tick, SHALL still count that tick, because r_start is still 1 in that cycle; the next cycle SHALL enter IDLE.
REQ-025 If i_go is dropped mid-period and re-raised, SHALL restart from counter 0 and the initial pattern, with no carried-over state.
REQ-026 SHALL drive o_led_on as ~pattern when ACTIVE_LOW=1, and as pattern otherwise.

Reset
REQ-027 While i_rst=1 at a clock edge, SHALL clear r_start, the counter, the pattern, the latched mode (to PULSE), the direction flag (to right) and o_wrap.
REQ-028 After reset, SHALL drive o_led_on to all ones when ACTIVE_LOW=1 and to all zeros otherwise; o_wrap SHALL be 0.
REQ-029 Reset SHALL take priority over every other input, including i_go and i_pls_1k in the same cycle.

Structure
REQ-030 Mode encodings (MODE_PULSE, MODE_TOGGLE, MODE_WALK, MODE_BOUNCE) and the direction constants SHALL live in the shared package led_pkg.
REQ-031 Counter, compare and wrap generation SHALL be one sub-module, led_tick_cnt (ports: clock, reset, enable, tick, period, wrap); pattern logic SHALL stay in led_pattern_gen.

Verification
REQ-032 Reset with ACTIVE_LOW=1, N_LED=8 -> o_led_on=8'hFF and o_wrap=0, held until the first wrap.
REQ-033 i_go=1, PULSE, i_period=3, tick every 4 clocks -> o_wrap every 3rd tick, one cycle wide, with o_led_on=8'h7F in exactly that cycle.
REQ-034 WALK, i_period=1, 9 ticks, ACTIVE_LOW=0 -> pattern 80,40,20,10,08,04,02,01,80 (hex).
REQ-035 BOUNCE, N_LED=4, i_period=1, ACTIVE_LOW=0 -> 8,4,2,1,2,4,8,4 (hex); switch to TOGGLE before the next wrap -> pattern 0 at that wrap, F at the following wrap.
REQ-036 Run with i_period=10, drop i_go at cnt=5, raise it 3 cycles later -> LEDs dark while IDLE, then a fresh count with the first wrap 10 ticks after restart.
REQ-037 i_period=0 -> a wrap on every tick; i_period changed from 10 to 2 at cnt=7 -> a wrap on the next tick.
